// File: rtl/sccb_cfg_seq.sv
// sccb_cfg_seq: walks a shared register ROM once per enabled camera channel,
// turning each ROM word into an SCCB write, a timed delay, or end-of-table.
// NACKed writes are re-issued a bounded number of times before the channel
// is abandoned. Per-channel done/fail flags summarise the last pass.
module sccb_cfg_seq #(
    parameter int NUM_CH     = 2,
    parameter int ADDR_W     = 8,
    parameter int GAP_CYC    = 100,
    parameter int DELAY_UNIT = 1000,
    parameter int MAX_RETRY  = 3,
    localparam int CW        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              restart,
    input  logic [NUM_CH-1:0] ch_mask,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [15:0]       rom_data,
    output logic              start,
    output logic [CW-1:0]     ch_sel,
    output logic [7:0]        reg_addr,
    output logic [7:0]        data,
    input  logic              done,
    input  logic              ack_err,
    output logic              busy,
    output logic [NUM_CH-1:0] cfg_done,
    output logic [NUM_CH-1:0] cfg_fail
);

    localparam int DLY_MAX = 255 * DELAY_UNIT;
    localparam int CNT_MAX = (DLY_MAX > GAP_CYC) ? DLY_MAX : GAP_CYC;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX + 1) : 1;
    localparam int RTY_W   = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    typedef enum logic [3:0] {
        IDLE, SEL_CH, FETCH, ISSUE, WAIT_DONE, GAP, DELAY, CH_END, DONE
    } state_t;

    state_t              state_r, state_s;
    logic                arm_r, arm_s;
    logic [NUM_CH-1:0]   pend_r, pend_s;
    logic [CNT_W-1:0]    cnt_r, cnt_s;
    logic [RTY_W-1:0]    retry_r, retry_s;
    logic [ADDR_W-1:0]   rom_addr_r, rom_addr_s;
    logic [CW-1:0]       ch_sel_r, ch_sel_s;
    logic [7:0]          reg_addr_r, reg_addr_s;
    logic [7:0]          data_r, data_s;
    logic                start_r, start_s;
    logic                busy_r, busy_s;
    logic [NUM_CH-1:0]   cfg_done_r, cfg_done_s;
    logic [NUM_CH-1:0]   cfg_fail_r, cfg_fail_s;

    logic                sel_found_s;
    logic [CW-1:0]       sel_idx_s;
    logic                is_end_s, is_dly_s, addr_last_s;
    logic [NUM_CH-1:0]   ch_bit_s;

    // Lowest-index pending channel; the descending loop lets the lowest set bit win.
    always_comb begin
        sel_found_s = 1'b0;
        sel_idx_s   = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (pend_r[i]) begin
                sel_found_s = 1'b1;
                sel_idx_s   = CW'(i);
            end else begin
                sel_found_s = sel_found_s;
            end
        end
    end

    assign is_end_s    = (rom_data == 16'hFFFF);
    assign is_dly_s    = (rom_data[15:8] == 8'hFF) && !is_end_s;
    assign addr_last_s = (rom_addr_r == {ADDR_W{1'b1}});
    assign ch_bit_s    = NUM_CH'(1) << ch_sel_r;

    // Next-state and next-output logic. rom_addr is always updated one state
    // ahead of FETCH (on entry to SEL_CH, GAP or DELAY) so the synchronous ROM
    // word is already valid when FETCH decodes it.
    always_comb begin
        state_s    = state_r;
        arm_s      = arm_r;
        pend_s     = pend_r;
        cnt_s      = cnt_r;
        retry_s    = retry_r;
        rom_addr_s = rom_addr_r;
        ch_sel_s   = ch_sel_r;
        reg_addr_s = reg_addr_r;
        data_s     = data_r;
        start_s    = 1'b0;
        busy_s     = busy_r;
        cfg_done_s = cfg_done_r;
        cfg_fail_s = cfg_fail_r;
        case (state_r)
            IDLE: begin
                // One settling cycle after reset release before the first pass.
                arm_s = 1'b1;
                if (arm_r) begin
                    pend_s     = ch_mask;
                    cfg_done_s = '0;
                    cfg_fail_s = '0;
                    busy_s     = 1'b1;
                    rom_addr_s = '0;
                    retry_s    = '0;
                    state_s    = SEL_CH;
                end else begin
                    busy_s = 1'b0;
                end
            end
            SEL_CH: begin
                rom_addr_s = '0;
                retry_s    = '0;
                if (sel_found_s) begin
                    ch_sel_s = sel_idx_s;
                    pend_s   = pend_r & ~(NUM_CH'(1) << sel_idx_s);
                    state_s  = FETCH;
                end else begin
                    busy_s  = 1'b0;
                    state_s = DONE;
                end
            end
            FETCH: begin
                if (is_end_s) begin
                    state_s = CH_END;
                end else if (addr_last_s) begin
                    cfg_fail_s = cfg_fail_r | ch_bit_s;
                    rom_addr_s = '0;
                    state_s    = SEL_CH;
                end else if (is_dly_s) begin
                    cnt_s      = CNT_W'(rom_data[7:0]) * CNT_W'(DELAY_UNIT);
                    rom_addr_s = rom_addr_r + ADDR_W'(1);
                    state_s    = DELAY;
                end else begin
                    reg_addr_s = rom_data[15:8];
                    data_s     = rom_data[7:0];
                    start_s    = 1'b1;
                    state_s    = ISSUE;
                end
            end
            ISSUE: begin
                state_s = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (!done) begin
                    state_s = WAIT_DONE;
                end else if (!ack_err) begin
                    retry_s    = '0;
                    rom_addr_s = rom_addr_r + ADDR_W'(1);
                    cnt_s      = CNT_W'(GAP_CYC);
                    state_s    = GAP;
                end else if (retry_r < RTY_W'(MAX_RETRY)) begin
                    retry_s = retry_r + RTY_W'(1);
                    cnt_s   = CNT_W'(GAP_CYC);
                    state_s = GAP;
                end else begin
                    cfg_fail_s = cfg_fail_r | ch_bit_s;
                    rom_addr_s = '0;
                    state_s    = SEL_CH;
                end
            end
            GAP, DELAY: begin
                // Both waits last max(1, loaded count) cycles.
                if (cnt_r <= CNT_W'(1)) begin
                    cnt_s   = '0;
                    state_s = FETCH;
                end else begin
                    cnt_s = cnt_r - CNT_W'(1);
                end
            end
            CH_END: begin
                cfg_done_s = cfg_done_r | ch_bit_s;
                rom_addr_s = '0;
                state_s    = SEL_CH;
            end
            DONE: begin
                busy_s     = 1'b0;
                rom_addr_s = '0;
                if (restart) begin
                    pend_s     = ch_mask;
                    cfg_done_s = '0;
                    cfg_fail_s = '0;
                    busy_s     = 1'b1;
                    retry_s    = '0;
                    state_s    = SEL_CH;
                end else begin
                    state_s = DONE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State and registered-output update with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r    <= IDLE;
            arm_r      <= 1'b0;
            pend_r     <= '0;
            cnt_r      <= '0;
            retry_r    <= '0;
            rom_addr_r <= '0;
            ch_sel_r   <= '0;
            reg_addr_r <= 8'h00;
            data_r     <= 8'h00;
            start_r    <= 1'b0;
            busy_r     <= 1'b0;
            cfg_done_r <= '0;
            cfg_fail_r <= '0;
        end else begin
            state_r    <= state_s;
            arm_r      <= arm_s;
            pend_r     <= pend_s;
            cnt_r      <= cnt_s;
            retry_r    <= retry_s;
            rom_addr_r <= rom_addr_s;
            ch_sel_r   <= ch_sel_s;
            reg_addr_r <= reg_addr_s;
            data_r     <= data_s;
            start_r    <= start_s;
            busy_r     <= busy_s;
            cfg_done_r <= cfg_done_s;
            cfg_fail_r <= cfg_fail_s;
        end
    end

    assign rom_addr = rom_addr_r;
    assign start    = start_r;
    assign ch_sel   = ch_sel_r;
    assign reg_addr = reg_addr_r;
    assign data     = data_r;
    assign busy     = busy_r;
    assign cfg_done = cfg_done_r;
    assign cfg_fail = cfg_fail_r;

endmodule

// File: tb/tb_sccb_cfg_seq.sv
// Directed bench for sccb_cfg_seq: synchronous ROM model, SCCB done/NACK
// responder, start-pulse logger, and a linear sequence of checked scenarios.
module tb_sccb_cfg_seq;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        restart = 1'b0;
    logic [1:0]  ch_mask = 2'b11;
    logic [3:0]  rom_addr;
    logic [15:0] rom_data;
    logic        start;
    logic [0:0]  ch_sel;
    logic [7:0]  reg_addr;
    logic [7:0]  data;
    logic        done = 1'b0;
    logic        ack_err = 1'b0;
    logic        busy;
    logic [1:0]  cfg_done;
    logic [1:0]  cfg_fail;

    logic [15:0] rom [16];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;

    int          n_start = 0;
    logic [16:0] log_ent [64];
    int          log_cyc [64];
    logic [1:0]  nack_ch = 2'b00;
    int          done_budget = -1;

    sccb_cfg_seq #(
        .NUM_CH(2), .ADDR_W(4), .GAP_CYC(4), .DELAY_UNIT(10), .MAX_RETRY(3)
    ) dut (
        .clk(clk), .rstn(rstn), .restart(restart), .ch_mask(ch_mask),
        .rom_addr(rom_addr), .rom_data(rom_data), .start(start),
        .ch_sel(ch_sel), .reg_addr(reg_addr), .data(data), .done(done),
        .ack_err(ack_err), .busy(busy), .cfg_done(cfg_done), .cfg_fail(cfg_fail)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) rom_data <= rom[rom_addr];

    // Log every start pulse as {ch_sel, reg_addr, data} with its cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (start === 1'b1 && n_start < 64) begin
                log_ent[n_start] = {ch_sel, reg_addr, data};
                log_cyc[n_start] = cyc;
                n_start = n_start + 1;
            end
        end
    end

    // Responder: done two cycles after each start, NACK per channel.
    initial begin
        int dly;
        dly = -1;
        forever begin
            @(negedge clk);
            done    = 1'b0;
            ack_err = 1'b0;
            if (rstn !== 1'b1) begin
                dly = -1;
            end else if (start === 1'b1) begin
                if (done_budget != 0) begin
                    dly = 2;
                    if (done_budget > 0) done_budget = done_budget - 1;
                end
            end else if (dly > 0) begin
                dly = dly - 1;
                if (dly == 0) begin
                    done    = 1'b1;
                    ack_err = nack_ch[ch_sel];
                    dly     = -1;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load3(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
        for (int i = 0; i < 16; i++) rom[i] = 16'hFFFF;
        rom[0] = a;
        rom[1] = b;
        rom[2] = c;
    endtask

    task automatic pulse_restart(output int c0);
        @(negedge clk);
        restart = 1'b1;
        c0 = cyc;
        @(negedge clk);
        restart = 1'b0;
    endtask

    task automatic wait_pass(input string tag);
        int t;
        t = 0;
        while (busy !== 1'b1 && t < 50) begin
            @(negedge clk);
            t = t + 1;
        end
        chk({tag, "_busy_rise"}, 32'(busy), 32'd1);
        t = 0;
        while (busy !== 1'b0 && t < 3000) begin
            @(negedge clk);
            t = t + 1;
        end
        chk({tag, "_busy_fall"}, 32'(busy), 32'd0);
    endtask

    function automatic int count_ch(input logic [0:0] ch);
        int n;
        n = 0;
        for (int i = 0; i < n_start && i < 64; i++) begin
            if (log_ent[i][16] == ch) n = n + 1;
        end
        return n;
    endfunction

    initial begin
        int c0;
        load3(16'h1234, 16'h5678, 16'hFFFF);

        // Reset values while rstn is held low.
        repeat (2) @(negedge clk);
        chk("rst_start", 32'(start), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rom_addr", 32'(rom_addr), 32'd0);
        chk("rst_cfg", 32'({cfg_done, cfg_fail}), 32'd0);
        chk("rst_bus", 32'({ch_sel, reg_addr, data}), 32'd0);

        // Two channels, clean ACKs, auto-start after release.
        @(negedge clk);
        rstn = 1'b1;
        c0 = cyc;
        wait_pass("basic");
        chk("basic_nstart", 32'(n_start), 32'd4);
        chk("basic_latency_ge4", 32'((log_cyc[0] - c0) >= 4), 32'd1);
        chk("basic_w0", 32'(log_ent[0]), 32'({1'b0, 8'h12, 8'h34}));
        chk("basic_w1", 32'(log_ent[1]), 32'({1'b0, 8'h56, 8'h78}));
        chk("basic_w2", 32'(log_ent[2]), 32'({1'b1, 8'h12, 8'h34}));
        chk("basic_w3", 32'(log_ent[3]), 32'({1'b1, 8'h56, 8'h78}));
        chk("basic_cfg_done", 32'(cfg_done), 32'd3);
        chk("basic_cfg_fail", 32'(cfg_fail), 32'd0);
        chk("basic_done_rom_addr", 32'(rom_addr), 32'd0);

        // Delay word: 3 ticks of 10 cycles before the single write.
        load3(16'hFF03, 16'h1201, 16'hFFFF);
        ch_mask = 2'b01;
        n_start = 0;
        pulse_restart(c0);
        wait_pass("delay");
        chk("delay_nstart", 32'(n_start), 32'd1);
        chk("delay_word", 32'(log_ent[0]), 32'({1'b0, 8'h12, 8'h01}));
        chk("delay_start_cycle", 32'(log_cyc[0] - c0), 32'd34);
        chk("delay_cfg_done", 32'(cfg_done), 32'd1);

        // Channel 0 always NACKs: 1 + 3 retries, then channel 1 completes.
        load3(16'h1234, 16'h5678, 16'hFFFF);
        ch_mask = 2'b11;
        nack_ch = 2'b01;
        n_start = 0;
        pulse_restart(c0);
        wait_pass("retry");
        chk("retry_ch0_starts", 32'(count_ch(1'b0)), 32'd4);
        chk("retry_ch0_word", 32'(log_ent[3]), 32'({1'b0, 8'h12, 8'h34}));
        chk("retry_ch1_starts", 32'(count_ch(1'b1)), 32'd2);
        chk("retry_cfg_fail", 32'(cfg_fail), 32'd1);
        chk("retry_cfg_done", 32'(cfg_done), 32'd2);
        nack_ch = 2'b00;

        // Only channel 1 enabled; restart and mask change while busy ignored.
        ch_mask = 2'b10;
        n_start = 0;
        pulse_restart(c0);
        ch_mask = 2'b01;
        repeat (3) @(negedge clk);
        pulse_restart(c0);
        wait_pass("mask");
        chk("mask_nstart", 32'(n_start), 32'd2);
        chk("mask_ch0_starts", 32'(count_ch(1'b0)), 32'd0);
        chk("mask_cfg_done", 32'(cfg_done), 32'd2);
        repeat (10) @(negedge clk);
        chk("mask_stays_idle", 32'({busy, 8'(n_start)}), 32'({1'b0, 8'd2}));

        // Restart during DONE repeats the pass with the mask captured then.
        ch_mask = 2'b10;
        n_start = 0;
        pulse_restart(c0);
        wait_pass("repeat");
        chk("repeat_w0", 32'(log_ent[0]), 32'({1'b1, 8'h12, 8'h34}));
        chk("repeat_nstart", 32'(n_start), 32'd2);

        // Reset asserted while waiting for done on the second write.
        ch_mask = 2'b11;
        n_start = 0;
        done_budget = 1;
        pulse_restart(c0);
        c0 = 0;
        while (n_start < 2 && c0 < 200) begin
            @(negedge clk);
            c0 = c0 + 1;
        end
        repeat (2) @(negedge clk);
        chk("wd_pre_rom_addr", 32'(rom_addr), 32'd1);
        chk("wd_pre_word", 32'({busy, reg_addr, data}), 32'({1'b1, 8'h56, 8'h78}));
        #2;
        rstn = 1'b0;
        #1;
        chk("wd_rst_outs", 32'({start, busy, ch_sel, rom_addr}), 32'd0);
        chk("wd_rst_word", 32'({reg_addr, data}), 32'd0);
        chk("wd_rst_cfg", 32'({cfg_done, cfg_fail}), 32'd0);
        @(negedge clk);
        done_budget = -1;
        n_start = 0;
        rstn = 1'b1;
        wait_pass("wd_restart");
        chk("wd_restart_w0", 32'(log_ent[0]), 32'({1'b0, 8'h12, 8'h34}));
        chk("wd_restart_nstart", 32'(n_start), 32'd4);
        chk("wd_restart_cfg_done", 32'(cfg_done), 32'd3);

        // No end marker: reaching the last ROM address fails the channel.
        for (int i = 0; i < 16; i++) rom[i] = 16'hFF00;
        ch_mask = 2'b01;
        n_start = 0;
        pulse_restart(c0);
        wait_pass("wrap");
        chk("wrap_nstart", 32'(n_start), 32'd0);
        chk("wrap_cfg_fail", 32'(cfg_fail), 32'd1);
        chk("wrap_cfg_done", 32'(cfg_done), 32'd0);

        // Empty mask: pass ends at once with both status vectors cleared.
        load3(16'h1234, 16'h5678, 16'hFFFF);
        ch_mask = 2'b00;
        n_start = 0;
        pulse_restart(c0);
        repeat (5) @(negedge clk);
        chk("empty_busy", 32'(busy), 32'd0);
        chk("empty_cfg", 32'({cfg_done, cfg_fail}), 32'd0);
        chk("empty_nstart", 32'(n_start), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
